// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one sync SRAM between display bursts and renderer.
// Optional VRAM_ARB_STATS_EN adds overrun and render-wait counters.
module vram_arbiter #(
  parameter int BURST_LEN    = 512,
  parameter int READ_LATENCY = 2
) (
  input  logic        i_master_clk,
  input  logic        i_reset,
  input  logic [19:0] i_vram_display_address,
  input  logic        i_vram_display_start,
  output logic [8:0]  o_vram_display_column,
  output logic [23:0] o_vram_display_data,
  output logic        o_vram_display_data_valid,
  output logic        o_vram_display_overrun,
  input  logic        i_render_req,
  input  logic        i_render_write,
  input  logic [19:0] i_render_address,
  input  logic [23:0] i_render_wdata,
  output logic        o_render_ack,
  output logic [23:0] o_render_rdata,
  output logic        o_render_rdata_valid,
  output logic [19:0] o_sram_address,
  output logic [23:0] o_sram_wdata,
  output logic        o_sram_we,
  output logic        o_sram_oe,
  input  logic [23:0] i_sram_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0] o_stat_overruns,
  output logic [15:0] o_stat_render_wait
`endif
);

  typedef enum logic [1:0] {IDLE, BURST, RENDER} state_t;

  localparam logic [8:0] LAST_COL = 9'(BURST_LEN - 1);

  state_t      state_q, state_d;
  logic [8:0]  col_q, col_d;
  logic [19:0] base_q, base_d;
  logic        pend_q, pend_d;
  logic [19:0] addr_q, addr_d;
  logic [23:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        oe_q, oe_d;
  logic        ack_q, ack_d;
  logic        ovr_q, ovr_d;
  logic        disp_q, disp_d;
  logic [8:0]  bcol_q, bcol_d;
  logic [10:0] pipe_q [READ_LATENCY];
  logic [10:0] tail;
  logic        dv_q, rv_q;
  logic [8:0]  dcol_q;
  logic [23:0] data_q;

  // next state, and the bus cycle the next state puts on the SRAM
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    base_d  = base_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    oe_d    = 1'b0;
    ack_d   = 1'b0;
    ovr_d   = 1'b0;
    disp_d  = 1'b0;
    bcol_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (i_vram_display_start || pend_q) begin
          state_d = BURST;
          col_d   = '0;
          pend_d  = 1'b0;
          ovr_d   = i_vram_display_start && pend_q;
          if (i_vram_display_start && !pend_q)
            base_d = i_vram_display_address;
        end else if (i_render_req) begin
          state_d = RENDER;
        end
      end
      BURST: begin
        ovr_d = i_vram_display_start;
        col_d = col_q + 9'd1;
        if (col_q == LAST_COL) begin
          col_d   = '0;
          state_d = i_render_req ? RENDER : IDLE;
        end
      end
      RENDER: begin
        if (i_vram_display_start) begin
          if (pend_q) begin
            ovr_d = 1'b1;
          end else begin
            pend_d = 1'b1;
            base_d = i_vram_display_address;
          end
        end
        if (pend_q) begin
          state_d = BURST;
          col_d   = '0;
          pend_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == BURST) begin
      addr_d = base_d + {11'd0, col_d};
      oe_d   = 1'b1;
      disp_d = 1'b1;
      bcol_d = col_d;
    end else if (state_d == RENDER) begin
      addr_d = i_render_address;
      we_d   = i_render_write;
      oe_d   = !i_render_write;
      ack_d  = 1'b1;
      if (i_render_write)
        wdata_d = i_render_wdata;
    end
  end

  // FSM state and registered SRAM bus
  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      base_q  <= '0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      oe_q    <= 1'b0;
      ack_q   <= 1'b0;
      ovr_q   <= 1'b0;
      disp_q  <= 1'b0;
      bcol_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      base_q  <= base_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      oe_q    <= oe_d;
      ack_q   <= ack_d;
      ovr_q   <= ovr_d;
      disp_q  <= disp_d;
      bcol_q  <= bcol_d;
    end
  end

  assign tail = pipe_q[READ_LATENCY-1];

  // read-return tags follow the SRAM latency, then capture the data
  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < READ_LATENCY; i++)
        pipe_q[i] <= '0;
      dv_q   <= 1'b0;
      rv_q   <= 1'b0;
      dcol_q <= '0;
      data_q <= '0;
    end else begin
      pipe_q[0] <= {oe_q, disp_q, bcol_q};
      for (int i = 1; i < READ_LATENCY; i++)
        pipe_q[i] <= pipe_q[i-1];
      dv_q <= tail[10] & tail[9];
      rv_q <= tail[10] & ~tail[9];
      if (tail[10]) begin
        dcol_q <= tail[8:0];
        data_q <= i_sram_rdata;
      end
    end
  end

  assign o_vram_display_column     = dcol_q;
  assign o_vram_display_data       = data_q;
  assign o_vram_display_data_valid = dv_q;
  assign o_vram_display_overrun    = ovr_q;
  assign o_render_ack              = ack_q;
  assign o_render_rdata            = data_q;
  assign o_render_rdata_valid      = rv_q;
  assign o_sram_address            = addr_q;
  assign o_sram_wdata              = wdata_q;
  assign o_sram_we                 = we_q;
  assign o_sram_oe                 = oe_q;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] novr_q, wait_q;

  // saturating counts of dropped starts and stalled render cycles
  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      novr_q <= '0;
      wait_q <= '0;
    end else begin
      if (ovr_d && novr_q != 16'hFFFF)
        novr_q <= novr_q + 16'd1;
      if (i_render_req && !ack_q && wait_q != 16'hFFFF)
        wait_q <= wait_q + 16'd1;
    end
  end

  assign o_stat_overruns    = novr_q;
  assign o_stat_render_wait = wait_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed and random stimulus for vram_arbiter,
// checked every cycle against a transaction-level model.
module tb_vram_arbiter;
  localparam int BL = 512;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [19:0] d_addr = '0;
  logic d_start = 1'b0;
  logic [8:0] d_col;
  logic [23:0] d_data;
  logic d_valid, d_ovr;
  logic r_req = 1'b0, r_wr = 1'b0;
  logic [19:0] r_addr = '0;
  logic [23:0] r_wdata = '0;
  logic r_ack, r_rvalid;
  logic [23:0] r_rdata;
  logic [19:0] s_addr;
  logic [23:0] s_wdata, s_rdata;
  logic s_we, s_oe;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.BURST_LEN(BL), .READ_LATENCY(RL)) dut (
    .i_master_clk(clk), .i_reset(rst),
    .i_vram_display_address(d_addr),
    .i_vram_display_start(d_start),
    .o_vram_display_column(d_col),
    .o_vram_display_data(d_data),
    .o_vram_display_data_valid(d_valid),
    .o_vram_display_overrun(d_ovr),
    .i_render_req(r_req), .i_render_write(r_wr),
    .i_render_address(r_addr), .i_render_wdata(r_wdata),
    .o_render_ack(r_ack), .o_render_rdata(r_rdata),
    .o_render_rdata_valid(r_rvalid),
    .o_sram_address(s_addr), .o_sram_wdata(s_wdata),
    .o_sram_we(s_we), .o_sram_oe(s_oe),
    .i_sram_rdata(s_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] init_word(input logic [19:0] a);
    return {a[11:0] ^ 12'h5A3, a[19:8]};
  endfunction

  // behavioural SRAM with RL-cycle read latency
  logic [23:0] sram [logic [19:0]];
  logic [23:0] rpipe [RL];
  logic [23:0] sram_rd;
  assign s_rdata = rpipe[RL-1];
  always @(posedge clk) begin
    sram_rd = sram.exists(s_addr) ? sram[s_addr] : init_word(s_addr);
    for (int i = RL - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
    rpipe[0] <= sram_rd;
    if (s_we) sram[s_addr] = s_wdata;
  end

  // transaction-level model
  typedef struct {
    int due;
    bit disp;
    logic [8:0] col;
    logic [23:0] data;
  } ret_t;
  ret_t rq[$];
  logic [23:0] shadow [logic [19:0]];
  int cyc = 0;
  int widx = 0;
  bit cur_burst = 0, was_render = 0, pend = 0;
  logic [19:0] bbase = '0, pbase = '0;
  bit e_oe, e_we, e_ack, e_ovr, e_dv, e_rv;
  logic [19:0] e_addr;
  logic [23:0] e_wdata, e_data;
  logic [8:0] e_col;

  function automatic logic [23:0] shadow_rd(input logic [19:0] a);
    return shadow.exists(a) ? shadow[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    bit busy, nb, nr;
    ret_t r;
    cyc++;
    e_oe = 0; e_we = 0; e_ack = 0; e_ovr = 0; e_dv = 0; e_rv = 0;
    if (rst) begin
      rq.delete();
      widx = 0; cur_burst = 0; was_render = 0; pend = 0;
    end else begin
      busy = cur_burst && (widx < BL);
      nb = 0; nr = 0;
      if (d_start) begin
        if (cur_burst || pend) e_ovr = 1;
        else begin pend = 1; pbase = d_addr; end
      end
      if (busy) nb = 1;
      else if (was_render) nb = 0;
      else if (pend) begin
        pend = 0; bbase = pbase; widx = 0; nb = 1;
      end else if (r_req) nr = 1;
      if (nb) begin
        e_oe = 1;
        e_addr = bbase + 20'(widx);
        r.due = cyc + RL + 1; r.disp = 1;
        r.col = 9'(widx); r.data = shadow_rd(e_addr);
        rq.push_back(r);
        widx++;
      end else if (nr) begin
        e_ack = 1; e_addr = r_addr; e_we = r_wr; e_oe = !r_wr;
        if (r_wr) begin
          e_wdata = r_wdata;
          shadow[r_addr] = r_wdata;
        end else begin
          r.due = cyc + RL + 1; r.disp = 0; r.col = 0;
          r.data = shadow_rd(r_addr);
          rq.push_back(r);
        end
      end
      cur_burst = nb;
      was_render = nr;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        e_dv = r.disp; e_rv = !r.disp;
        e_col = r.col; e_data = r.data;
      end
    end
  end

  // per-cycle comparison against the model
  int nvalid = 0;
  int fv_cyc = 0;
  logic [8:0] last_col = '0;
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs_zero", 32'(|{d_col, d_data, d_valid, d_ovr, r_ack,
          r_rdata, r_rvalid, s_addr, s_wdata, s_we, s_oe}), 32'd0);
    end else begin
      chk("ctl_oe_we_ack_ovr_dv_rv",
          32'({s_oe, s_we, r_ack, d_ovr, d_valid, r_rvalid}),
          32'({e_oe, e_we, e_ack, e_ovr, e_dv, e_rv}));
      if (e_oe || e_we) chk("sram_addr", 32'(s_addr), 32'(e_addr));
      if (e_we) chk("sram_wdata", 32'(s_wdata), 32'(e_wdata));
      if (e_dv) begin
        chk("disp_col", 32'(d_col), 32'(e_col));
        chk("disp_data", 32'(d_data), 32'(e_data));
      end
      if (e_rv) chk("render_rdata", 32'(r_rdata), 32'(e_data));
      if (d_valid) begin
        if (nvalid == 0) fv_cyc = cyc;
        nvalid++;
        last_col = d_col;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int s_cyc, w;
    ticks(3);
    rst = 1'b0;
    tick();
    chk("reset_idle_oe", 32'(s_oe), 32'd0);

    // 1: single burst from 0x80000
    nvalid = 0;
    d_addr = 20'h80000; d_start = 1'b1;
    tick();
    d_start = 1'b0;
    s_cyc = cyc;
    chk("t1_first_addr", 32'({s_oe, s_addr}), 32'({1'b1, 20'h80000}));
    ticks(BL - 1);
    chk("t1_last_addr", 32'({s_oe, s_addr}), 32'({1'b1, 20'h801FF}));
    tick();
    chk("t1_bus_free", 32'(s_oe), 32'd0);
    ticks(10);
    chk("t1_valids", nvalid, BL);
    chk("t1_last_col", 32'(last_col), 32'd511);
    chk("t1_first_valid_lag", fv_cyc - s_cyc, RL + 1);

    // 2: write then read back
    r_req = 1'b1; r_wr = 1'b1; r_addr = 20'h00010; r_wdata = 24'hABCDEF;
    tick();
    chk("t2_write_ack", 32'({r_ack, s_we, s_addr}), 32'({2'b11, 20'h00010}));
    r_req = 1'b0;
    tick();
    r_req = 1'b1; r_wr = 1'b0;
    tick();
    chk("t2_read_ack", 32'({r_ack, s_oe}), 32'b11);
    r_req = 1'b0;
    ticks(3);
    chk("t2_read_data", 32'({r_rvalid, r_rdata}), 32'({1'b1, 24'hABCDEF}));

    // 3: start and render req together, base near the top of memory
    d_addr = 20'hFFF00; d_start = 1'b1;
    r_req = 1'b1; r_wr = 1'b0; r_addr = 20'h00010;
    w = 1;
    tick();
    d_start = 1'b0;
    while (!r_ack && w < 1000) begin
      w++;
      tick();
    end
    r_req = 1'b0;
    chk("t3_render_wait", w, 513);
    ticks(10);

    // 4: start during a render cycle
    r_req = 1'b1; r_wr = 1'b1; r_addr = 20'h00020; r_wdata = 24'h123456;
    tick();
    chk("t4_render_ack", 32'(r_ack), 32'd1);
    r_req = 1'b0;
    nvalid = 0;
    d_addr = 20'h40000; d_start = 1'b1;
    tick();
    d_start = 1'b0;
    tick();
    chk("t4_burst_addr", 32'({s_oe, s_addr}), 32'({1'b1, 20'h40000}));
    ticks(BL + 10);
    chk("t4_valids", nvalid, BL);

    // 5: second start mid-burst
    nvalid = 0;
    d_addr = 20'h00100; d_start = 1'b1;
    tick();
    d_start = 1'b0;
    ticks(100);
    d_addr = 20'h55555; d_start = 1'b1;
    tick();
    d_start = 1'b0;
    chk("t5_overrun", 32'(d_ovr), 32'd1);
    tick();
    chk("t5_overrun_1cyc", 32'(d_ovr), 32'd0);
    ticks(BL);
    chk("t5_valids", nvalid, BL);

    // 6: reset mid-burst
    d_addr = 20'h7FF00; d_start = 1'b1;
    tick();
    d_start = 1'b0;
    ticks(200);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_zero", 32'(|{s_oe, s_addr, d_valid, r_ack, d_col, d_data}),
        32'd0);
    tick();
    tick();
    rst = 1'b0;
    nvalid = 0;
    ticks(10);
    chk("t6_no_stale_valid", nvalid, 0);
    d_addr = 20'h00200; d_start = 1'b1;
    tick();
    d_start = 1'b0;
    ticks(BL + 10);
    chk("t6_new_burst", nvalid, BL);

    // random mix
    for (int i = 0; i < 4000; i++) begin
      d_start = ($urandom_range(0, 199) == 0);
      d_addr = 20'($urandom);
      if (r_req && r_ack) r_req = 1'b0;
      else if (!r_req && $urandom_range(0, 2) == 0) begin
        r_req = 1'b1;
        r_wr = 1'($urandom_range(0, 1));
        r_addr = 20'($urandom_range(0, 31));
        r_wdata = 24'($urandom);
      end
      tick();
    end
    d_start = 1'b0;
    r_req = 1'b0;
    ticks(BL + 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
